// File: rtl/sb_pkg.sv
// Shared constants and helpers for the register scoreboard.
package sb_pkg;

  localparam int NREG_DEF  = 32;
  localparam int AW_DEF    = 5;
  localparam int CNT_W_DEF = 2;

  localparam logic [AW_DEF-1:0] REG_ZERO = '0;

  // Largest value an in-flight counter may hold before new writers must stall.
  function automatic int unsigned cnt_sat(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode-side bundle for the register scoreboard: candidate, issue and writeback in; stall/status out.
interface reg_scoreboard_if
  import sb_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF,
  parameter int NRD  = 2
);

  logic [NRD-1:0]    rd_used;
  logic [NRD*AW-1:0] rd_addr;
  logic              cand_we;
  logic [AW-1:0]     cand_waddr;
  logic              cand_late;
  logic              issue_valid;
  logic              wb_valid;
  logic [AW-1:0]     wb_waddr;
  logic              flush;
  logic              stall;
  logic [NREG-1:0]   busy_vec;
  logic              err;

  modport master (
    output rd_used, rd_addr, cand_we, cand_waddr, cand_late,
           issue_valid, wb_valid, wb_waddr, flush,
    input  stall, busy_vec, err
  );

  modport slave (
    input  rd_used, rd_addr, cand_we, cand_waddr, cand_late,
           issue_valid, wb_valid, wb_waddr, flush,
    output stall, busy_vec, err
  );

endinterface

// File: rtl/sb_entry.sv
// One tracked register: in-flight writer counter plus the late flag of its youngest writer.
module sb_entry #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             issue_hit,
  input  logic             wb_hit,
  input  logic             late_in,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             late
);

  logic [CNT_W-1:0] count_d;
  logic             late_d;

  always_comb begin
    count_d = count;
    late_d  = late;
    if (flush) begin
      count_d = '0;
      late_d  = 1'b0;
    end else if (issue_hit && wb_hit) begin
      late_d = late_in;
    end else if (issue_hit) begin
      count_d = count + CNT_W'(1);
      late_d  = late_in;
    end else if (wb_hit && (count != '0)) begin
      count_d = count - CNT_W'(1);
      if (count == CNT_W'(1)) begin
        late_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
      late  <= 1'b0;
    end else begin
      count <= count_d;
      late  <= late_d;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard beside ID: per-register writer counters and a combinational decode stall.
// Build option SB_FWD_EN: when defined, only late-result producers stall consumers.
module reg_scoreboard
  import sb_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int AW    = AW_DEF,
  parameter int NRD   = 2,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  reg_scoreboard_if.slave   sb
);

  localparam logic [CNT_W-1:0] SAT  = CNT_W'(cnt_sat(CNT_W));
  localparam logic [AW-1:0]    ZERO = AW'(REG_ZERO);
`ifdef SB_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic [CNT_W-1:0] cnt    [NREG];
  logic             late_q [NREG];
  logic [AW-1:0]    rd_a   [NRD];
  logic [NRD-1:0]   haz;
  logic             sat;
  logic             stall_c;
  logic             issue_fire;
  logic             wb_fire;
  logic             err_q;
  logic [NREG-1:0]  busy;

  assign wb_fire    = sb.wb_valid && (sb.wb_waddr != ZERO);
  assign issue_fire = sb.issue_valid && !stall_c && sb.cand_we && (sb.cand_waddr != ZERO);

  // Register 0 is never tracked; its slot reads as permanently idle.
  assign cnt[0]    = '0;
  assign late_q[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    sb_entry #(.CNT_W(CNT_W)) u_entry (
      .clk       (clk),
      .resetn    (resetn),
      .issue_hit (issue_fire && (sb.cand_waddr == AW'(r))),
      .wb_hit    (wb_fire && (sb.wb_waddr == AW'(r))),
      .late_in   (sb.cand_late),
      .flush     (sb.flush),
      .count     (cnt[r]),
      .late      (late_q[r])
    );
  end

  // A last writer retiring this cycle is supplied by regfile write-through, so it is no hazard.
  for (genvar i = 0; i < NRD; i++) begin : g_port
    assign rd_a[i] = sb.rd_addr[i*AW +: AW];
    assign haz[i]  = sb.rd_used[i] && (rd_a[i] != ZERO) && (cnt[rd_a[i]] != '0)
                     && (!FWD_EN || late_q[rd_a[i]])
                     && !(wb_fire && (sb.wb_waddr == rd_a[i]) && (cnt[rd_a[i]] == CNT_W'(1)));
  end

  assign sat = sb.cand_we && (sb.cand_waddr != ZERO) && (cnt[sb.cand_waddr] == SAT)
               && !(wb_fire && (sb.wb_waddr == sb.cand_waddr));

  assign stall_c = (|haz) || sat;

  always_comb begin
    busy = '0;
    for (int r = 1; r < NREG; r++) begin
      busy[r] = (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (wb_fire && (cnt[sb.wb_waddr] == '0)) begin
      err_q <= 1'b1;
    end
  end

  assign sb.stall    = stall_c;
  assign sb.busy_vec = busy;
  assign sb.err      = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard; expectations follow SB_FWD_EN when it is defined.
module tb_reg_scoreboard;

  logic clk;
  logic resetn;

  reg_scoreboard_if #(.NREG(32), .AW(5), .NRD(2)) sb_if ();

  reg_scoreboard #(.NREG(32), .AW(5), .NRD(2), .CNT_W(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sb     (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SB_FWD_EN
  localparam logic NF = 1'b0;
`else
  localparam logic NF = 1'b1;
`endif

  typedef struct {
    string       nm;
    logic [1:0]  ru;
    logic [4:0]  ra;
    logic        cw;
    logic [4:0]  wa;
    logic        lt;
    logic        iv;
    logic        wv;
    logic [4:0]  wba;
    logic        fl;
    logic        es;
    logic [31:0] eb;
    logic        ee;
  } row_t;

  typedef struct {
    string       nm;
    logic        stall;
    logic [31:0] busy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic row_t mk(input string nm, input logic [1:0] ru, input logic [4:0] ra,
                              input logic cw, input logic [4:0] wa, input logic lt,
                              input logic iv, input logic wv, input logic [4:0] wba,
                              input logic fl, input logic es, input logic [31:0] eb,
                              input logic ee);
    row_t x;
    x.nm = nm; x.ru = ru; x.ra = ra; x.cw = cw; x.wa = wa; x.lt = lt;
    x.iv = iv; x.wv = wv; x.wba = wba; x.fl = fl; x.es = es; x.eb = eb; x.ee = ee;
    return x;
  endfunction

  function automatic logic [31:0] bm(input int n);
    logic [31:0] v;
    v    = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic set_idle();
    sb_if.rd_used     = '0;
    sb_if.rd_addr     = '0;
    sb_if.cand_we     = 1'b0;
    sb_if.cand_waddr  = '0;
    sb_if.cand_late   = 1'b0;
    sb_if.issue_valid = 1'b0;
    sb_if.wb_valid    = 1'b0;
    sb_if.wb_waddr    = '0;
    sb_if.flush       = 1'b0;
  endtask

  // Applies one cycle of stimulus and queues what the DUT must show before the next edge.
  task automatic drive(input row_t x);
    exp_t e;
    sb_if.rd_used     = x.ru;
    sb_if.rd_addr     = {x.ra, x.ra};
    sb_if.cand_we     = x.cw;
    sb_if.cand_waddr  = x.wa;
    sb_if.cand_late   = x.lt;
    sb_if.issue_valid = x.iv;
    sb_if.wb_valid    = x.wv;
    sb_if.wb_waddr    = x.wba;
    sb_if.flush       = x.fl;
    e.nm = x.nm; e.stall = x.es; e.busy = x.eb; e.err = x.ee;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("rst_active",  2'b01, 5, 1, 5, 1, 1, 1, 9, 0, 0, 0, 0));
    rows.push_back(mk("rst_held",    2'b11, 5, 1, 5, 0, 1, 1, 5, 0, 0, 0, 0));
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (sb_if.stall !== e.stall || sb_if.busy_vec !== e.busy || sb_if.err !== e.err) begin
        bad++;
        $display("FAIL reset/%s: got stall=%b busy=%h err=%b, want stall=%b busy=%h err=%b",
                 e.nm, sb_if.stall, sb_if.busy_vec, sb_if.err, e.stall, e.busy, e.err);
      end
      @(posedge clk); #1;
    end
    set_idle();
    resetn = 1'b1;
    @(posedge clk); #1;
    drive(mk("rd5_empty", 2'b01, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (sb_if.stall !== e.stall || sb_if.busy_vec !== e.busy || sb_if.err !== e.err) begin
      bad++;
      $display("FAIL reset/%s: got stall=%b busy=%h err=%b, want stall=%b busy=%h err=%b",
               e.nm, sb_if.stall, sb_if.busy_vec, sb_if.err, e.stall, e.busy, e.err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fwd();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("iss5",    2'b00, 0, 1, 5, 0, 1, 0, 0, 0, 0,  0,     0));
    rows.push_back(mk("rd5",     2'b01, 5, 0, 0, 0, 0, 0, 0, 0, NF, bm(5), 0));
    rows.push_back(mk("rd5_p1",  2'b10, 5, 0, 0, 0, 0, 0, 0, 0, NF, bm(5), 0));
    rows.push_back(mk("rd5_wb",  2'b01, 5, 0, 0, 0, 0, 1, 5, 0, 0,  bm(5), 0));
    rows.push_back(mk("rd5_done",2'b11, 5, 0, 0, 0, 0, 0, 0, 0, 0,  0,     0));
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (sb_if.stall !== e.stall || sb_if.busy_vec !== e.busy || sb_if.err !== e.err) begin
        bad++;
        $display("FAIL fwd/%s: got stall=%b busy=%h err=%b, want stall=%b busy=%h err=%b",
                 e.nm, sb_if.stall, sb_if.busy_vec, sb_if.err, e.stall, e.busy, e.err);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_late_order();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("iss7_L",     2'b00, 0, 1, 7, 1, 1, 0, 0, 0, 0,  0,     0));
    rows.push_back(mk("iss7_N",     2'b00, 0, 1, 7, 0, 1, 0, 0, 0, 0,  bm(7), 0));
    rows.push_back(mk("rd7_yN",     2'b01, 7, 0, 0, 0, 0, 0, 0, 0, NF, bm(7), 0));
    rows.push_back(mk("rd7_wb_c2",  2'b01, 7, 0, 0, 0, 0, 1, 7, 0, NF, bm(7), 0));
    rows.push_back(mk("rd7_wb_c1",  2'b01, 7, 0, 0, 0, 0, 1, 7, 0, 0,  bm(7), 0));
    rows.push_back(mk("iss7_N2",    2'b00, 0, 1, 7, 0, 1, 0, 0, 0, 0,  0,     0));
    rows.push_back(mk("iss7_L2",    2'b00, 0, 1, 7, 1, 1, 0, 0, 0, 0,  bm(7), 0));
    rows.push_back(mk("rd7_yL_p1",  2'b10, 7, 0, 0, 0, 0, 0, 0, 0, 1,  bm(7), 0));
    rows.push_back(mk("nord7",      2'b00, 7, 0, 0, 0, 0, 0, 0, 0, 0,  bm(7), 0));
    rows.push_back(mk("rd7L_wb_c2", 2'b01, 7, 0, 0, 0, 0, 1, 7, 0, 1,  bm(7), 0));
    rows.push_back(mk("rd7L_wb_c1", 2'b01, 7, 0, 0, 0, 0, 1, 7, 0, 0,  bm(7), 0));
    rows.push_back(mk("rd7_empty",  2'b01, 7, 0, 0, 0, 0, 0, 0, 0, 0,  0,     0));
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (sb_if.stall !== e.stall || sb_if.busy_vec !== e.busy || sb_if.err !== e.err) begin
        bad++;
        $display("FAIL late/%s: got stall=%b busy=%h err=%b, want stall=%b busy=%h err=%b",
                 e.nm, sb_if.stall, sb_if.busy_vec, sb_if.err, e.stall, e.busy, e.err);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("iss3_a",     2'b00, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0,     0));
    rows.push_back(mk("iss3_b",     2'b00, 0, 1, 3, 0, 1, 0, 0, 0, 0, bm(3), 0));
    rows.push_back(mk("iss3_c",     2'b00, 0, 1, 3, 0, 1, 0, 0, 0, 0, bm(3), 0));
    rows.push_back(mk("sat_iv",     2'b00, 0, 1, 3, 0, 1, 0, 0, 0, 1, bm(3), 0));
    rows.push_back(mk("sat_noiv",   2'b00, 0, 1, 3, 0, 0, 0, 0, 0, 1, bm(3), 0));
    rows.push_back(mk("sat_wb",     2'b00, 0, 1, 3, 0, 1, 1, 3, 0, 0, bm(3), 0));
    rows.push_back(mk("sat_again",  2'b00, 0, 1, 3, 0, 1, 0, 0, 0, 1, bm(3), 0));
    rows.push_back(mk("wb3_c3",     2'b00, 0, 0, 0, 0, 0, 1, 3, 0, 0, bm(3), 0));
    rows.push_back(mk("wb3_c2",     2'b00, 0, 0, 0, 0, 0, 1, 3, 0, 0, bm(3), 0));
    rows.push_back(mk("rd3_wb_c1",  2'b01, 3, 0, 0, 0, 0, 1, 3, 0, 0, bm(3), 0));
    rows.push_back(mk("r3_empty",   2'b01, 3, 1, 3, 0, 0, 0, 0, 0, 0, 0,     0));
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (sb_if.stall !== e.stall || sb_if.busy_vec !== e.busy || sb_if.err !== e.err) begin
        bad++;
        $display("FAIL sat/%s: got stall=%b busy=%h err=%b, want stall=%b busy=%h err=%b",
                 e.nm, sb_if.stall, sb_if.busy_vec, sb_if.err, e.stall, e.busy, e.err);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_same_cycle_flush();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("iss4",      2'b00, 0, 1, 4, 0, 1, 0, 0, 0, 0, 0,             0));
    rows.push_back(mk("iss4_wb4",  2'b00, 0, 1, 4, 0, 1, 1, 4, 0, 0, bm(4),         0));
    rows.push_back(mk("wb4",       2'b00, 0, 0, 0, 0, 0, 1, 4, 0, 0, bm(4),         0));
    rows.push_back(mk("idle4",     2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0));
    rows.push_back(mk("iss4_L",    2'b00, 0, 1, 4, 1, 1, 0, 0, 0, 0, 0,             0));
    rows.push_back(mk("iss6_L",    2'b00, 0, 1, 6, 1, 1, 0, 0, 0, 0, bm(4),         0));
    rows.push_back(mk("fl_iss8",   2'b00, 0, 1, 8, 0, 1, 0, 0, 1, 0, bm(4) | bm(6), 0));
    rows.push_back(mk("post_fl",   2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0));
    rows.push_back(mk("iss6_L2",   2'b00, 0, 1, 6, 1, 1, 0, 0, 0, 0, 0,             0));
    rows.push_back(mk("rd6_fl",    2'b01, 6, 0, 0, 0, 0, 0, 0, 1, 1, bm(6),         0));
    rows.push_back(mk("rd6_post",  2'b01, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0));
    rows.push_back(mk("iss0",      2'b00, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0,             0));
    rows.push_back(mk("wb0",       2'b01, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,             0));
    rows.push_back(mk("idle0",     2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0));
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (sb_if.stall !== e.stall || sb_if.busy_vec !== e.busy || sb_if.err !== e.err) begin
        bad++;
        $display("FAIL same/%s: got stall=%b busy=%h err=%b, want stall=%b busy=%h err=%b",
                 e.nm, sb_if.stall, sb_if.busy_vec, sb_if.err, e.stall, e.busy, e.err);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_err_async_reset();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("wb9_c0",   2'b00, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0,     0));
    rows.push_back(mk("err_set",  2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     1));
    rows.push_back(mk("err_fl",   2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,     1));
    rows.push_back(mk("err_keep", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     1));
    rows.push_back(mk("iss2",     2'b00, 0, 1, 2, 1, 1, 0, 0, 0, 0, 0,     1));
    rows.push_back(mk("busy2",    2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, bm(2), 1));
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (sb_if.stall !== e.stall || sb_if.busy_vec !== e.busy || sb_if.err !== e.err) begin
        bad++;
        $display("FAIL err/%s: got stall=%b busy=%h err=%b, want stall=%b busy=%h err=%b",
                 e.nm, sb_if.stall, sb_if.busy_vec, sb_if.err, e.stall, e.busy, e.err);
      end
      @(posedge clk); #1;
    end
    // Reset lands mid-cycle; state must clear well before the next rising edge.
    set_idle();
    sb_if.rd_used = 2'b01;
    sb_if.rd_addr = {5'd2, 5'd2};
    #1 resetn = 1'b0;
    #1;
    total++;
    if (sb_if.stall !== 1'b0 || sb_if.busy_vec !== 32'h0 || sb_if.err !== 1'b0) begin
      bad++;
      $display("FAIL err/async_rst: got stall=%b busy=%h err=%b, want stall=0 busy=00000000 err=0",
               sb_if.stall, sb_if.busy_vec, sb_if.err);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    drive(mk("post_rst", 2'b01, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (sb_if.stall !== e.stall || sb_if.busy_vec !== e.busy || sb_if.err !== e.err) begin
      bad++;
      $display("FAIL err/%s: got stall=%b busy=%h err=%b, want stall=%b busy=%h err=%b",
               e.nm, sb_if.stall, sb_if.busy_vec, sb_if.err, e.stall, e.busy, e.err);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    resetn = 1'b0;
    set_idle();
    @(posedge clk); #1;
    test_reset();
    test_fwd();
    test_late_order();
    test_saturation();
    test_same_cycle_flush();
    test_err_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
